max7219_if_arbiter: RTL

//  Shares one max7219_if serializer between G_NB_REQ frame sources (static cmd decoder, scroller, ...).

---
 rtl/max7219_if_arbiter_pkg.sv | 19 +
 rtl/max7219_if_arbiter_if.sv | 29 ++
 rtl/max7219_if_arbiter_rr_pick.sv | 41 ++++
 rtl/max7219_if_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/max7219_if_arbiter_pkg.sv
// Shared types and helpers for the MAX7219 serializer arbiter.
// FSM encoding and the round-robin index increment live here so the picker and top agree.
package max7219_arb_pkg;

    localparam int C_MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        HOLD
    } t_arb_state;

    // Increment with an explicit wrap so non-power-of-2 requester counts never skip or overrun.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/max7219_if_arbiter_if.sv
// Requester-side and serializer-side signals of the MAX7219 arbiter.
// The arbiter takes the slave view; requesters and the max7219_if side take the master view.
interface max7219_if_arbiter_if #(
    parameter int G_NB_REQ     = 2,
    parameter int G_DATA_WIDTH = 16
);
    logic [G_NB_REQ-1:0]              i_req_valid;
    logic [G_NB_REQ-1:0]              i_req_en_load;
    logic [G_NB_REQ*G_DATA_WIDTH-1:0] i_req_data;
    logic [G_NB_REQ-1:0]              o_req_ack;
    logic [G_NB_REQ-1:0]              o_req_done;
    logic [G_NB_REQ-1:0]              o_req_grant;
    logic                             o_max7219_if_start;
    logic                             o_max7219_if_en_load;
    logic [G_DATA_WIDTH-1:0]          o_max7219_if_data;
    logic                             i_max7219_if_done;

    modport slave (
        input  i_req_valid, i_req_en_load, i_req_data, i_max7219_if_done,
        output o_req_ack, o_req_done, o_req_grant,
        output o_max7219_if_start, o_max7219_if_en_load, o_max7219_if_data
    );

    modport master (
        output i_req_valid, i_req_en_load, i_req_data, i_max7219_if_done,
        input  o_req_ack, o_req_done, o_req_grant,
        input  o_max7219_if_start, o_max7219_if_en_load, o_max7219_if_data
    );
endinterface

// File: rtl/max7219_if_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid at or after ptr, or only the owner while a burst holds.
module max7219_rr_pick
    import max7219_arb_pkg::*;
#(
    parameter  int G_NB_REQ = 2,
    localparam int IW       = $clog2(G_NB_REQ)
) (
    input  logic [G_NB_REQ-1:0] valid,
    input  logic [IW-1:0]       ptr,
    input  logic                hold_en,
    input  logic [IW-1:0]       owner,
    output logic [G_NB_REQ-1:0] winner,
    output logic [IW-1:0]       winner_idx,
    output logic                any
);
    logic [IW:0] sum;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        sum        = '0;
        if (hold_en) begin
            if (valid[owner]) begin
                winner[owner] = 1'b1;
                winner_idx    = owner;
                any           = 1'b1;
            end
        end else begin
            for (int i = 0; i < G_NB_REQ; i++) begin
                sum = {1'b0, ptr} + (IW + 1)'(i);
                if (sum >= (IW + 1)'(G_NB_REQ)) sum = sum - (IW + 1)'(G_NB_REQ);
                if (!any && valid[sum[IW-1:0]]) begin
                    winner[sum[IW-1:0]] = 1'b1;
                    winner_idx          = sum[IW-1:0];
                    any                 = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/max7219_if_arbiter.sv
// Shares one max7219_if serializer between G_NB_REQ frame sources with round-robin
// arbitration, burst locking until an en_load frame, and a watchdog release.
module max7219_if_arbiter
    import max7219_arb_pkg::*;
#(
    parameter  int G_NB_REQ      = 2,
    parameter  int G_DATA_WIDTH  = 16,
    parameter  int G_TIMEOUT_CYC = 4096,
    localparam int IW            = $clog2(G_NB_REQ),
    localparam int WDW           = (G_TIMEOUT_CYC > 1) ? $clog2(G_TIMEOUT_CYC) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    max7219_if_arbiter_if.slave   bus,
    output logic                  o_busy,
    output logic                  o_timeout
);
    t_arb_state              state_q, state_d;
    logic [IW-1:0]           ptr_q, owner_q;
    logic [G_NB_REQ-1:0]     grant_q, done_q;
    logic [G_DATA_WIDTH-1:0] data_q;
    logic                    en_load_q, timeout_q;
    logic [WDW-1:0]          wd_cnt;

    logic [G_NB_REQ-1:0]     pick;
    logic [IW-1:0]           pick_idx;
    logic                    pick_any;
    logic                    capture, release_own, done_pulse, timeout_d, wd_expire;

    max7219_rr_pick #(.G_NB_REQ(G_NB_REQ)) u_pick (
        .valid      (bus.i_req_valid),
        .ptr        (ptr_q),
        .hold_en    (state_q == HOLD),
        .owner      (owner_q),
        .winner     (pick),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    assign wd_expire = (G_TIMEOUT_CYC != 0) && (wd_cnt == WDW'(G_TIMEOUT_CYC - 1));

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        release_own = 1'b0;
        done_pulse  = 1'b0;
        timeout_d   = 1'b0;
        unique case (state_q)
            IDLE, HOLD: begin
                // In HOLD the picker only offers the owner; done pulses here are stray and dropped.
                if (pick_any) begin
                    state_d = ISSUE;
                    capture = 1'b1;
                end else if (state_q == HOLD && wd_expire) begin
                    state_d     = IDLE;
                    release_own = 1'b1;
                    timeout_d   = 1'b1;
                end
            end
            ISSUE: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.i_max7219_if_done) begin
                    done_pulse = 1'b1;
                    if (en_load_q) begin
                        state_d     = IDLE;
                        release_own = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (wd_expire) begin
                    state_d     = IDLE;
                    release_own = 1'b1;
                    timeout_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: capture registers are reset too because they drive outputs that must read 0 after reset.
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            data_q    <= '0;
            en_load_q <= 1'b0;
            timeout_q <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_pulse ? grant_q : '0;
            timeout_q <= timeout_d;
            if (capture) begin
                owner_q   <= pick_idx;
                grant_q   <= pick;
                data_q    <= bus.i_req_data[pick_idx*G_DATA_WIDTH +: G_DATA_WIDTH];
                en_load_q <= bus.i_req_en_load[pick_idx];
            end
            if (release_own) begin
                grant_q <= '0;
                ptr_q   <= IW'(wrap_inc(32'(owner_q), G_NB_REQ));
            end
            // Watchdog restarts on every entry into WAIT_DONE or HOLD.
            if (state_d != state_q || !(state_q inside {WAIT_DONE, HOLD})) wd_cnt <= '0;
            else                                                          wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign bus.o_max7219_if_start   = (state_q == ISSUE);
    assign bus.o_req_ack            = (state_q == ISSUE) ? grant_q : '0;
    assign bus.o_req_done           = done_q;
    assign bus.o_req_grant          = grant_q;
    assign bus.o_max7219_if_data    = data_q;
    assign bus.o_max7219_if_en_load = en_load_q;
    assign o_busy                   = (state_q != IDLE);
    assign o_timeout                = timeout_q;
endmodule
